// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: keypad game FSM owning screens, BCD counters, cursor, selection and buzzer request
module game_flow_ctrl #(
  parameter int NUM_MAX = 5,
  parameter logic [39:0] INIT_STATUS = 40'h1111111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] btn,
  output logic [1:0]  state,
  output logic [39:0] status,
  output logic [3:0]  cursor,
  output logic [2:0]  num,
  output logic [9:0]  sel_mask,
  output logic        buzz_req,
  output logic        apply_done
);
  localparam logic [1:0] START = 2'd0, HELP = 2'd1, CHOOSE = 2'd2, PLAY = 2'd3;
  localparam logic [2:0] NMAX = 3'(NUM_MAX);
  logic [15:0] btn_q, p;
  logic [1:0]  state_n;
  logic [2:0]  sel_cnt;
  logic [3:0]  cur_val;
  logic [39:0] applied;
  logic        has_zero;
  assign cur_val = status[{cursor, 2'b00} +: 4];
  // presses are registered once more so every action lands one edge after the rising sample
  always_ff @(posedge clk)
    if (rst) begin
      btn_q <= 16'hFFFF;
      p     <= '0;
    end else begin
      btn_q <= btn;
      p     <= btn & ~btn_q;
    end
  always_ff @(posedge clk)
    state <= rst ? START : state_n;
  always_comb begin
    state_n = state;
    case (state)
      START:   state_n = p[15] ? HELP  : p[14] ? CHOOSE : START;
      HELP:    state_n = p[13] ? START : p[14] ? CHOOSE : HELP;
      CHOOSE:  state_n = p[12] ? START : p[14] ? PLAY   : CHOOSE;
      default: state_n = p[12] ? START : PLAY;
    endcase
  end
  always_comb begin
    applied  = status;
    has_zero = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (sel_mask[k]) applied[4*k +: 4] = status[4*k +: 4] == 4'd9 ? 4'd0 : status[4*k +: 4] + 4'd1;
      if (status[4*k +: 4] == 4'd0) has_zero = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      status     <= INIT_STATUS;
      cursor     <= '0;
      num        <= 3'd1;
      sel_mask   <= '0;
      sel_cnt    <= '0;
      buzz_req   <= 1'b0;
      apply_done <= 1'b0;
    end else begin
      apply_done <= 1'b0;
      buzz_req   <= state == PLAY && has_zero;
      if (state != PLAY && state_n == PLAY) begin
        status   <= INIT_STATUS;
        cursor   <= '0;
        sel_mask <= '0;
        sel_cnt  <= '0;
      end else if (state == CHOOSE && !p[12] && !p[14] && p[11]) begin
        num <= num == NMAX ? 3'd1 : num + 3'd1;
      end else if (state == PLAY) begin
        if (p[12]) begin
          sel_mask <= '0;
          sel_cnt  <= '0;
        end else if (p[3]) begin
          status     <= applied;
          sel_mask   <= '0;
          sel_cnt    <= '0;
          apply_done <= 1'b1;
        end else if (p[10]) begin
          if (sel_mask[cursor]) begin
            sel_mask[cursor] <= 1'b0;
            sel_cnt          <= sel_cnt - 3'd1;
          end else if (sel_cnt < num) begin
            sel_mask[cursor] <= 1'b1;
            sel_cnt          <= sel_cnt + 3'd1;
          end
        end else if (p[7]) begin
          cursor <= cursor == 4'd0 ? 4'd9 : cursor - 4'd1;
        end else if (p[5]) begin
          cursor <= cursor == 4'd9 ? 4'd0 : cursor + 4'd1;
        end else if (p[2]) begin
          status[{cursor, 2'b00} +: 4] <= cur_val == 4'd9 ? 4'd0 : cur_val + 4'd1;
        end else if (p[6]) begin
          status[{cursor, 2'b00} +: 4] <= cur_val == 4'd0 ? 4'd9 : cur_val - 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed-vector bench for game_flow_ctrl
module tb_game_flow_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] btn = '0;
  logic [1:0]  state;
  logic [39:0] status;
  logic [3:0]  cursor;
  logic [2:0]  num;
  logic [9:0]  sel_mask;
  logic        buzz_req, apply_done;
  int checks = 0, errors = 0;
  game_flow_ctrl dut (
    .clk(clk), .rst(rst), .btn(btn), .state(state), .status(status), .cursor(cursor),
    .num(num), .sel_mask(sel_mask), .buzz_req(buzz_req), .apply_done(apply_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // rising edge sampled, then action edge; outputs are stable at the return
  task automatic press(input logic [15:0] v);
    btn = v;
    @(negedge clk);
    btn = '0;
    @(negedge clk);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_state"}, 40'(state), 40'd0);
    chk({tag, "_status"}, status, 40'h1111111111);
    chk({tag, "_cursor"}, 40'(cursor), 40'd0);
    chk({tag, "_num"}, 40'(num), 40'd1);
    chk({tag, "_mask"}, 40'(sel_mask), 40'd0);
    chk({tag, "_buzz"}, 40'(buzz_req), 40'd0);
    chk({tag, "_apply"}, 40'(apply_done), 40'd0);
  endtask
  initial begin
    rst = 1'b1;
    btn = 16'h4000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset("rst");
    repeat (3) @(negedge clk);
    chk("held_key14", 40'(state), 40'd0);
    btn = '0;
    @(negedge clk);
    btn = 16'h4000;
    @(negedge clk);
    chk("latency_1cyc", 40'(state), 40'd0);
    btn = '0;
    @(negedge clk);
    chk("latency_2cyc", 40'(state), 40'd2);
    for (int i = 0; i < 5; i++) begin
      press(16'h0800);
      chk("num_inc", 40'(num), i == 4 ? 40'd1 : 40'(i + 2));
    end
    press(16'h4000);
    chk("enter_play", 40'(state), 40'd3);
    chk("play_status", status, 40'h1111111111);
    chk("play_cursor", 40'(cursor), 40'd0);
    press(16'h0080);
    chk("cursor_wrap_down", 40'(cursor), 40'd9);
    for (int i = 0; i < 9; i++) press(16'h0004);
    chk("inc_wrap", status, 40'h0111111111);
    chk("buzz_lag", 40'(buzz_req), 40'd0);
    @(negedge clk);
    chk("buzz_on", 40'(buzz_req), 40'd1);
    press(16'h0040);
    chk("dec_wrap", status, 40'h9111111111);
    @(negedge clk);
    chk("buzz_off", 40'(buzz_req), 40'd0);
    press(16'h0020);
    chk("cursor_wrap_up", 40'(cursor), 40'd0);
    press(16'h1000);
    chk("quit_state", 40'(state), 40'd0);
    chk("quit_status", status, 40'h9111111111);
    press(16'h4000);
    press(16'h0800);
    chk("num2", 40'(num), 40'd2);
    press(16'h4000);
    chk("replay_status", status, 40'h1111111111);
    press(16'h0400);
    chk("mark0", 40'(sel_mask), 40'd1);
    press(16'h0400);
    chk("unmark0", 40'(sel_mask), 40'd0);
    press(16'h0400);
    press(16'h0020);
    press(16'h0400);
    press(16'h0020);
    press(16'h0400);
    chk("mark_limit", 40'(sel_mask), 40'h3);
    press(16'h0008);
    chk("apply_status", status, 40'h1111111122);
    chk("apply_mask", 40'(sel_mask), 40'd0);
    chk("apply_pulse", 40'(apply_done), 40'd1);
    @(negedge clk);
    chk("apply_pulse_end", 40'(apply_done), 40'd0);
    press(16'h0400);
    chk("mark2", 40'(sel_mask), 40'h4);
    press(16'h1008);
    chk("quit_over_apply", 40'(state), 40'd0);
    chk("quit_keep_status", status, 40'h1111111122);
    chk("quit_no_apply", 40'(apply_done), 40'd0);
    chk("quit_clear_mask", 40'(sel_mask), 40'd0);
    press(16'h8000);
    chk("help", 40'(state), 40'd1);
    press(16'h2000);
    chk("help_back", 40'(state), 40'd0);
    press(16'h4000);
    press(16'h4000);
    press(16'h0400);
    chk("pre_rst_mask", 40'(sel_mask), 40'd1);
    btn = 16'h0008;
    @(negedge clk);
    rst = 1'b1;
    btn = '0;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst_apply");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Registered game-flow controller for the keypad counter game: it replaces the per-state key handling in the top level with one clocked FSM. It takes the debounced 16-key matrix-keypad vector, detects key presses, sequences the four screens (start, help, choose, play), and owns the 40-bit `status` register holding ten BCD counters. It also owns the cursor, the selection mask and count, and the buzzer request. The per-nibble buzzer instances and the display read its outputs directly.

## Interface
- `NUM_MAX`, 5 — maximum number of counters markable per apply (1..7)
- `INIT_STATUS`, 40'h1111111111 — counter values loaded at reset and on every entry to PLAY; every nibble must be 0..9
- `clk` input 1 — system clock; single clock domain
- `rst` input 1 — reset, synchronous, active-high
- `btn` input 16 — keypad level vector, already synchronised to `clk`; bit i high while key i is held
- `state` output 2 — 00 START, 01 HELP, 10 CHOOSE, 11 PLAY
- `status` output 40 — ten 4-bit BCD counters; counter k is `status[4k+3:4k]`
- `cursor` output 4 — index of the selected counter, 0..9
- `num` output 3 — selection limit chosen in CHOOSE, 1..NUM_MAX
- `sel_mask` output 10 — marked counters
- `buzz_req` output 1 — high while in PLAY and any counter equals 0
- `apply_done` output 1 — one-cycle pulse after an apply

## Operation
- Press detection: `press[i] = btn[i] & ~btn_q[i]`, where `btn_q` is `btn` registered.
  - `btn_q` resets to 16'hFFFF, so a key held through reset produces no press.
- Only the highest-priority press that is legal in the current state is acted on in a cycle. All other presses in that cycle are discarded.
- START:
  - key 15 → HELP.
  - else key 14 → CHOOSE.
- HELP:
  - key 13 → START.
  - else key 14 → CHOOSE.
- CHOOSE:
  - key 12 → START.
  - else key 14 → PLAY.
  - else key 11: `num` increments; NUM_MAX wraps to 1.
- Entering PLAY, in the same edge as the transition:
  - `status` ← INIT_STATUS.
  - `cursor` ← 0.
  - `sel_mask` ← 0.
  - `sel_cnt` ← 0.
- PLAY actions, highest priority first:
  - key 12: → START. `status` is retained, `sel_mask` is cleared.
  - key 3, apply: every counter with its mask bit set does 9→0, else +1. Then `sel_mask` and `sel_cnt` clear and `apply_done` pulses. An apply with an empty mask still pulses `apply_done` and changes nothing.
  - key 10, toggle mark at `cursor`:
    - If the bit is set: clear it and decrement `sel_cnt`.
    - If the bit is clear and `sel_cnt < num`: set it and increment `sel_cnt`.
    - If the bit is clear and `sel_cnt == num`: ignore.
  - key 7: `cursor` − 1, 0 wraps to 9.
  - else key 5: `cursor` + 1, 9 wraps to 0.
  - key 2: counter at `cursor` +1, 9 wraps to 0.
  - else key 6: counter at `cursor` −1, 0 wraps to 9.
- Keys not listed for a state are ignored.
- `num` is held across PLAY and is only changed in CHOOSE.
- Arithmetic: counters always stay in 0..9. The internal `sel_cnt` is 3 bits, never exceeds `num`, and always equals popcount(`sel_mask`).

## Timing
- Every output is a register. There is no combinational path from input to output.
- Reset values: `state`=START, `status`=INIT_STATUS, `cursor`=0, `num`=1, `sel_mask`=0, `buzz_req`=0, `apply_done`=0.
- Latency: if `btn[i]` is first seen high at clock edge n, the resulting state, counter or cursor change is visible after edge n+1. `apply_done` is high for the cycle after edge n+1.
- `buzz_req` is registered from post-update values, so it lags `status` by one cycle. It drops one cycle after leaving PLAY.
- Holding a key produces exactly one action. Release plus re-press is needed to repeat.
- `rst` has priority over any press in the same cycle, including in the middle of an apply.

## Test plan
- Reset with `btn`=16'h4000 held → no transition. Release, then press key 14 → `state`=CHOOSE exactly 2 cycles after the press sample.
- In CHOOSE, press key 11 five times with NUM_MAX=5 → `num` goes 2,3,4,5,1. Press key 14 → PLAY, `status`=40'h1111111111, `cursor`=0.
- In PLAY, press key 7 once → `cursor`=9. Press key 2 nine times → counter 9 reaches 0, then `buzz_req`=1 one cycle later. Press key 6 → counter 9 = 9 and `buzz_req` falls.
- With `num`=2, mark counters 0, 1 and 2 (key 10 with cursor moves) → `sel_mask`=10'b0000000011. Press key 3 → counters 0 and 1 = 2, `sel_mask`=0, `apply_done` pulses once.
- Keys 12 and 3 rising in the same cycle in PLAY → `state`=START, `status` unchanged, no `apply_done`.
- Assert `rst` in the same cycle as a key 3 press with a non-empty mask → all outputs at reset values next cycle.
